// File: rtl/ad7656_emu_responder.sv
// Emulates the AD7656 parallel read interface: CONVST starts a timed BUSY window,
// then six latched channel words are served on DB by successive CS/RD strobes.
module ad7656_emu_responder #(
  parameter int CONV_CYCLES = 300,
  parameter int NUM_CH      = 6
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        convst_A_i,
  input  logic        convst_B_i,
  input  logic        convst_C_i,
  input  logic        cs_n_i,
  input  logic        rd_n_i,
  input  logic [15:0] ch1_data_i,
  input  logic [15:0] ch2_data_i,
  input  logic [15:0] ch3_data_i,
  input  logic [15:0] ch4_data_i,
  input  logic [15:0] ch5_data_i,
  input  logic [15:0] ch6_data_i,
  output logic        busy_o,
  output logic [15:0] db_o,
  output logic        db_oe_o,
  output logic        sample_latched_o,
  output logic        overrun_err_o
);

  localparam int CNT_W = 10;
  localparam int PTR_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);
  // Bit order {rd_n, cs_n, convst_C, convst_B, convst_A}; strobes idle high, CONVST idle low
  localparam logic [4:0] SYNC_IDLE = 5'b11000;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_READY} state_t;

  logic [4:0] async_in;
  logic [4:0] s2_vec;
  logic [4:0] s3_vec;

  assign async_in = {rd_n_i, cs_n_i, convst_C_i, convst_B_i, convst_A_i};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sync
      logic s1_reg, s2_reg, s3_reg;
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          s1_reg <= SYNC_IDLE[gi];
          s2_reg <= SYNC_IDLE[gi];
          s3_reg <= SYNC_IDLE[gi];
        end else begin
          s1_reg <= async_in[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end
      assign s2_vec[gi] = s2_reg;
      assign s3_vec[gi] = s3_reg;
    end
  endgenerate

  logic conv_rise, rd_fall, rd_rise, rd_low, cs_act, cs_release;
  assign conv_rise  = |(s2_vec[2:0] & ~s3_vec[2:0]);
  assign rd_fall    = s3_vec[4] & ~s2_vec[4];
  assign rd_rise    = ~s3_vec[4] & s2_vec[4];
  assign rd_low     = ~s2_vec[4];
  assign cs_act     = ~s2_vec[3];
  assign cs_release = s2_vec[3] & ~s3_vec[3];

  logic [15:0] ch_in [NUM_CH];
  assign ch_in[0] = ch1_data_i;
  assign ch_in[1] = ch2_data_i;
  assign ch_in[2] = ch3_data_i;
  assign ch_in[3] = ch4_data_i;
  assign ch_in[4] = ch5_data_i;
  assign ch_in[5] = ch6_data_i;

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic [15:0]        db_reg, db_next;
  logic               db_oe_reg, db_oe_next;
  logic               latched_reg, latched_next;
  logic               overrun_reg, overrun_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        shadow_reg [NUM_CH];
  logic [15:0]        shadow_next [NUM_CH];
  logic               start_conv;

  always_comb begin
    state_next   = state_reg;
    busy_next    = busy_reg;
    db_next      = db_reg;
    db_oe_next   = db_oe_reg;
    rd_ptr_next  = rd_ptr_reg;
    cnt_next     = cnt_reg;
    shadow_next  = shadow_reg;
    latched_next = 1'b0;
    overrun_next = 1'b0;
    start_conv   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (conv_rise) begin
          start_conv = 1'b1;
        end else if (rd_fall) begin
          db_next    = 16'h0000;
          db_oe_next = 1'b1;
        end else if (rd_rise) begin
          db_oe_next = 1'b0;
        end
      end
      ST_CONV: begin
        cnt_next = cnt_reg + 1'b1;
        if (conv_rise) overrun_next = 1'b1;
        // Reads while busy return zeros without touching the read pointer
        if (rd_fall) begin
          db_next    = 16'h0000;
          db_oe_next = 1'b1;
        end else if (rd_rise) begin
          db_oe_next = 1'b0;
        end
        if (cnt_reg == CNT_LAST) begin
          busy_next   = 1'b0;
          rd_ptr_next = '0;
          state_next  = ST_READY;
        end
      end
      ST_READY: begin
        if (conv_rise) begin
          start_conv = 1'b1;
        end else if (rd_fall && cs_act) begin
          db_next    = shadow_reg[rd_ptr_reg];
          db_oe_next = 1'b1;
        end else if (rd_rise && cs_act) begin
          db_oe_next  = 1'b0;
          rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // CS dropped mid-strobe aborts the word without consuming it
    if (cs_release && rd_low && !start_conv) db_oe_next = 1'b0;

    if (start_conv) begin
      shadow_next  = ch_in;
      latched_next = 1'b1;
      busy_next    = 1'b1;
      cnt_next     = '0;
      rd_ptr_next  = '0;
      state_next   = ST_CONV;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= ST_IDLE;
      busy_reg    <= 1'b0;
      db_reg      <= 16'h0000;
      db_oe_reg   <= 1'b0;
      latched_reg <= 1'b0;
      overrun_reg <= 1'b0;
      rd_ptr_reg  <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      busy_reg    <= busy_next;
      db_reg      <= db_next;
      db_oe_reg   <= db_oe_next;
      latched_reg <= latched_next;
      overrun_reg <= overrun_next;
      rd_ptr_reg  <= rd_ptr_next;
      cnt_reg     <= cnt_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_shadow
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) shadow_reg[gi] <= 16'h0000;
        else          shadow_reg[gi] <= shadow_next[gi];
      end
    end
  endgenerate

  assign busy_o           = busy_reg;
  assign db_o             = db_reg;
  assign db_oe_o          = db_oe_reg;
  assign sample_latched_o = latched_reg;
  assign overrun_err_o    = overrun_reg;

endmodule
